// File: rtl/ads8688_manchn_ctrl_if.sv
// Command/result handshake between a requester and the ADS8688 manual-channel controller.
// The requester drives start and chsel; the controller returns the done pulse and the captured sample.
interface ads8688_manchn_ctrl_if;
  logic        manchn_start;
  logic [15:0] chsel;
  logic        manchn_done;
  logic [15:0] ch_data;

  modport master (
    output manchn_start,
    output chsel,
    input  manchn_done,
    input  ch_data
  );

  modport slave (
    input  manchn_start,
    input  chsel,
    output manchn_done,
    output ch_data
  );
endinterface

// File: rtl/ads8688_manchn_ctrl.sv
// ADS8688 manual-channel-select frame engine: 32-SCLK SPI frame, command out on MOSI, result captured from MISO.
// Define ADS8688_MISO_FALL_SAMPLE_EN to capture MISO on SCLK falling edges instead of rising edges.
module ads8688_manchn_ctrl #(
  parameter int SCLK_HALF = 2,
  parameter int CSN_IDLE  = 2
) (
  input  logic                         clk,
  input  logic                         arstn,
  ads8688_manchn_ctrl_if.slave         ctrl,
  output logic                         sclk,
  output logic                         csn,
  output logic                         mosi,
  input  logic                         miso
);

  localparam int DIV_W  = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int IDLE_W = (CSN_IDLE > 1) ? $clog2(CSN_IDLE) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(SCLK_HALF - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(CSN_IDLE - 1);

`ifdef ADS8688_MISO_FALL_SAMPLE_EN
  localparam logic FALL_SAMPLE = 1'b1;
`else
  localparam logic FALL_SAMPLE = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [DIV_W-1:0]   div_reg, div_next;
  logic [6:0]         half_reg, half_next;
  logic [IDLE_W-1:0]  idle_reg, idle_next;
  logic [31:0]        frame_reg, frame_next;
  logic [15:0]        cap_reg, cap_next;
  logic [15:0]        ch_data_reg, ch_data_next;
  logic               sclk_reg, sclk_next;
  logic               csn_reg, csn_next;
  logic               mosi_reg, mosi_next;
  logic               done_reg, done_next;

  // half_reg counts SCLK half-periods elapsed since the frame start edge;
  // edge_num is the index of the half-period boundary landing on this clk edge.
  logic       half_tick;
  logic [6:0] edge_num;
  logic       is_rise;
  logic       is_fall;
  logic       is_end;
  logic       idle_exit;
  logic       busy;
  logic       start_ok;
  logic       cap_en;

  assign half_tick = (div_reg == DIV_MAX);
  assign edge_num  = half_reg + 7'd1;
  assign is_rise   = half_tick && edge_num[0] && (edge_num != 7'd65);
  assign is_fall   = half_tick && !edge_num[0];
  assign is_end    = half_tick && (edge_num == 7'd65);
  assign idle_exit = (idle_reg == IDLE_MAX);
  assign busy      = (state_reg == ST_SETUP) || (state_reg == ST_SHIFT);
  // A start on the last DONE cycle is taken directly, so held starts leave csn high exactly CSN_IDLE cycles.
  assign start_ok  = ctrl.manchn_start &&
                     ((state_reg == ST_IDLE) || ((state_reg == ST_DONE) && idle_exit));
  // Result bits live in SCLK cycles 17..32: rising edges 33..63 or falling edges 34..64.
  assign cap_en    = FALL_SAMPLE ? (is_fall && (edge_num >= 7'd34))
                                 : (is_rise && (edge_num >= 7'd33));

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_ok) state_next = ST_SETUP;
      ST_SETUP: if (is_rise)  state_next = ST_SHIFT;
      ST_SHIFT: if (is_end)   state_next = ST_DONE;
      ST_DONE:  if (idle_exit) state_next = start_ok ? ST_SETUP : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    div_next     = div_reg;
    half_next    = half_reg;
    idle_next    = idle_reg;
    frame_next   = frame_reg;
    cap_next     = cap_reg;
    ch_data_next = ch_data_reg;
    sclk_next    = sclk_reg;
    csn_next     = csn_reg;
    mosi_next    = mosi_reg;
    done_next    = 1'b0;

    if (start_ok) begin
      frame_next = {ctrl.chsel, 16'h0000};
      csn_next   = 1'b0;
      sclk_next  = 1'b0;
      mosi_next  = ctrl.chsel[15];
      div_next   = '0;
      half_next  = '0;
      cap_next   = '0;
    end else if (busy) begin
      if (half_tick) begin
        div_next  = '0;
        half_next = edge_num;
      end else begin
        div_next = div_reg + DIV_W'(1);
      end

      if (is_rise) begin
        sclk_next = 1'b1;
      end
      // Next command bit moves up into frame_reg[30] so MOSI is stable before the following rise.
      if (is_fall) begin
        sclk_next  = 1'b0;
        mosi_next  = frame_reg[30];
        frame_next = {frame_reg[30:0], 1'b0};
      end
      if (cap_en) begin
        cap_next = {cap_reg[14:0], miso};
      end
      if (is_end) begin
        csn_next     = 1'b1;
        sclk_next    = 1'b0;
        mosi_next    = 1'b0;
        ch_data_next = cap_reg;
        done_next    = 1'b1;
        idle_next    = '0;
      end
    end else if (state_reg == ST_DONE) begin
      if (!idle_exit) begin
        idle_next = idle_reg + IDLE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      div_reg     <= '0;
      half_reg    <= '0;
      idle_reg    <= '0;
      frame_reg   <= '0;
      cap_reg     <= '0;
      ch_data_reg <= '0;
      sclk_reg    <= 1'b0;
      csn_reg     <= 1'b1;
      mosi_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      div_reg     <= div_next;
      half_reg    <= half_next;
      idle_reg    <= idle_next;
      frame_reg   <= frame_next;
      cap_reg     <= cap_next;
      ch_data_reg <= ch_data_next;
      sclk_reg    <= sclk_next;
      csn_reg     <= csn_next;
      mosi_reg    <= mosi_next;
      done_reg    <= done_next;
    end
  end

  assign sclk             = sclk_reg;
  assign csn              = csn_reg;
  assign mosi             = mosi_reg;
  assign ctrl.manchn_done = done_reg;
  assign ctrl.ch_data     = ch_data_reg;

endmodule

// File: tb/tb_ads8688_manchn_ctrl.sv
// Directed bench for ads8688_manchn_ctrl: default instance plus a SCLK_HALF=1 instance, each with a small ADC model.
// The MISO model follows ADS8688_MISO_FALL_SAMPLE_EN so the captured word matches in either build.
module tb_ads8688_manchn_ctrl;

  logic clk;
  logic arstn;

  ads8688_manchn_ctrl_if ctrl0 ();
  ads8688_manchn_ctrl_if ctrl1 ();

  logic sclk0, csn0, mosi0, miso0;
  logic sclk1, csn1, mosi1, miso1;

  ads8688_manchn_ctrl dut0 (
    .clk   (clk),
    .arstn (arstn),
    .ctrl  (ctrl0),
    .sclk  (sclk0),
    .csn   (csn0),
    .mosi  (mosi0),
    .miso  (miso0)
  );

  ads8688_manchn_ctrl #(.SCLK_HALF(1), .CSN_IDLE(2)) dut1 (
    .clk   (clk),
    .arstn (arstn),
    .ctrl  (ctrl1),
    .sclk  (sclk1),
    .csn   (csn1),
    .mosi  (mosi1),
    .miso  (miso1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] adc_word [2];

  logic sclk_a [2];
  logic csn_a  [2];
  logic mosi_a [2];
  logic done_a [2];
  assign sclk_a[0] = sclk0;
  assign sclk_a[1] = sclk1;
  assign csn_a[0]  = csn0;
  assign csn_a[1]  = csn1;
  assign mosi_a[0] = mosi0;
  assign mosi_a[1] = mosi1;
  assign done_a[0] = ctrl0.manchn_done;
  assign done_a[1] = ctrl1.manchn_done;

  // Per-instance bus monitor, sampled on the falling clk edge.
  logic        sclk_prev [2];
  logic        csn_prev  [2];
  int          falls     [2];
  int          rises_f   [2];
  int          rise_tot  [2];
  int          csn_low   [2];
  int          done_tot  [2];
  int          high_run  [2];
  int          gap_last  [2];
  logic [31:0] mosi_word [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      sclk_prev[i] = 1'b0;
      csn_prev[i]  = 1'b1;
      falls[i]     = 0;
      rises_f[i]   = 0;
      rise_tot[i]  = 0;
      csn_low[i]   = 0;
      done_tot[i]  = 0;
      high_run[i]  = 0;
      gap_last[i]  = 0;
      mosi_word[i] = 32'h0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (csn_a[i]) begin
        falls[i]    <= 0;
        rises_f[i]  <= 0;
        high_run[i] <= high_run[i] + 1;
      end else begin
        if (csn_prev[i]) gap_last[i] <= high_run[i];
        high_run[i] <= 0;
        csn_low[i]  <= csn_low[i] + 1;
        if (sclk_a[i] && !sclk_prev[i]) rises_f[i] <= rises_f[i] + 1;
        if (!sclk_a[i] && sclk_prev[i]) falls[i] <= falls[i] + 1;
      end
      if (sclk_a[i] && !sclk_prev[i]) begin
        rise_tot[i]  <= rise_tot[i] + 1;
        mosi_word[i] <= {mosi_word[i][30:0], mosi_a[i]};
      end
      if (done_a[i]) done_tot[i] <= done_tot[i] + 1;
      sclk_prev[i] <= sclk_a[i];
      csn_prev[i]  <= csn_a[i];
    end
  end

  // ADC model: result bit for SCLK cycle 17..32, changing opposite to the sampling edge.
  function automatic logic miso_bit(input logic [15:0] w, input int n_fall, input int n_rise);
`ifdef ADS8688_MISO_FALL_SAMPLE_EN
    if (n_rise >= 17 && n_rise <= 32) return w[32 - n_rise];
`else
    if (n_fall >= 16 && n_fall <= 31) return w[31 - n_fall];
`endif
    return 1'b0;
  endfunction

  assign miso0 = miso_bit(adc_word[0], falls[0], rises_f[0]);
  assign miso1 = miso_bit(adc_word[1], falls[1], rises_f[1]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input int which, input logic [15:0] cs);
    if (which == 0) begin
      ctrl0.chsel = cs;
      ctrl0.manchn_start = 1'b1;
    end else begin
      ctrl1.chsel = cs;
      ctrl1.manchn_start = 1'b1;
    end
    tick();
    ctrl0.manchn_start = 1'b0;
    ctrl1.manchn_start = 1'b0;
  endtask

  task automatic wait_done(input int which, input int limit);
    int n;
    n = 0;
    while (!done_a[which] && n < limit) begin
      tick();
      n++;
    end
    check("done_seen", {31'd0, done_a[which]}, 32'd1);
  endtask

  int low0, rise0, done0, n;
  logic [15:0] exp1;

  initial begin
    arstn = 1'b0;
    ctrl0.manchn_start = 1'b0;
    ctrl1.manchn_start = 1'b0;
    ctrl0.chsel = 16'h0000;
    ctrl1.chsel = 16'h0000;
    adc_word[0] = 16'h0000;
    adc_word[1] = 16'h0000;
    tick();
    tick();
    check("rst_csn",  {31'd0, csn0}, 32'd1);
    check("rst_sclk", {31'd0, sclk0}, 32'd0);
    check("rst_mosi", {31'd0, mosi0}, 32'd0);
    check("rst_done", {31'd0, ctrl0.manchn_done}, 32'd0);
    check("rst_data", {16'd0, ctrl0.ch_data}, 32'd0);
    arstn = 1'b1;
    tick();
    tick();

    // Basic frame
    adc_word[0] = 16'hA5A5;
    low0 = csn_low[0]; rise0 = rise_tot[0]; done0 = done_tot[0];
    pulse_start(0, 16'hC400);
    wait_done(0, 300);
    check("basic_mosi",   mosi_word[0], 32'hC400_0000);
    check("basic_rises",  rise_tot[0] - rise0, 32);
    check("basic_csnlow", csn_low[0] - low0, 130);
    check("basic_data",   {16'd0, ctrl0.ch_data}, 32'h0000_A5A5);
    tick();
    check("basic_done1",  done_tot[0] - done0, 1);
    $display("[TB] basic frame chsel=0xC400 ch_data=0x%04h", ctrl0.ch_data);
    repeat (5) tick();

    // Start while busy is ignored
    adc_word[0] = 16'h3C5A;
    done0 = done_tot[0];
    pulse_start(0, 16'hC400);
    repeat (39) tick();
    pulse_start(0, 16'hC800);
    wait_done(0, 300);
    check("busy_mosi", mosi_word[0], 32'hC400_0000);
    check("busy_data", {16'd0, ctrl0.ch_data}, 32'h0000_3C5A);
    repeat (200) tick();
    check("busy_done1", done_tot[0] - done0, 1);
    check("busy_idle_csn", {31'd0, csn0}, 32'd1);
    $display("[TB] busy frame ch_data=0x%04h", ctrl0.ch_data);

    // Reset mid-frame
    done0 = done_tot[0];
    pulse_start(0, 16'hC400);
    repeat (69) @(posedge clk);
    #2;
    arstn = 1'b0;
    #1;
    check("rstmid_csn",  {31'd0, csn0}, 32'd1);
    check("rstmid_sclk", {31'd0, sclk0}, 32'd0);
    check("rstmid_data", {16'd0, ctrl0.ch_data}, 32'd0);
    tick();
    tick();
    arstn = 1'b1;
    check("rstmid_nodone", done_tot[0] - done0, 0);
    adc_word[0] = 16'h5AC3;
    low0 = csn_low[0];
    pulse_start(0, 16'hC000);
    check("rstmid_first_edge", {31'd0, csn0}, 32'd0);
    wait_done(0, 300);
    check("rstmid_csnlow", csn_low[0] - low0, 130);
    check("rstmid_data2", {16'd0, ctrl0.ch_data}, 32'h0000_5AC3);
    $display("[TB] frame after reset ch_data=0x%04h", ctrl0.ch_data);
    repeat (5) tick();

    // Start held high: back-to-back frames
    done0 = done_tot[0];
    adc_word[0] = 16'h1E0F;
    ctrl0.chsel = 16'hD000;
    ctrl0.manchn_start = 1'b1;
    wait_done(0, 300);
    check("b2b_mosi1", mosi_word[0], 32'hD000_0000);
    check("b2b_data1", {16'd0, ctrl0.ch_data}, 32'h0000_1E0F);
    ctrl0.chsel = 16'hC000;
    adc_word[0] = 16'hF00D;
    n = 0;
    while (csn0 && n < 10) begin
      tick();
      n++;
    end
    check("b2b_gap", gap_last[0], 2);
    ctrl0.manchn_start = 1'b0;
    repeat (50) tick();
    check("b2b_hold", {16'd0, ctrl0.ch_data}, 32'h0000_1E0F);
    wait_done(0, 300);
    check("b2b_mosi2", mosi_word[0], 32'hC000_0000);
    check("b2b_data2", {16'd0, ctrl0.ch_data}, 32'h0000_F00D);
    repeat (10) tick();
    check("b2b_done2", done_tot[0] - done0, 2);
    $display("[TB] back-to-back frames ch_data=0x%04h", ctrl0.ch_data);

    // SCLK_HALF=1 instance
`ifdef ADS8688_MISO_FALL_SAMPLE_EN
    exp1 = 16'h1234;
`else
    exp1 = 16'hFFFF;
`endif
    adc_word[1] = exp1;
    low0 = csn_low[1]; rise0 = rise_tot[1];
    pulse_start(1, 16'hC800);
    wait_done(1, 200);
    check("h1_csnlow", csn_low[1] - low0, 65);
    check("h1_rises",  rise_tot[1] - rise0, 32);
    check("h1_mosi",   mosi_word[1], 32'hC800_0000);
    check("h1_data",   {16'd0, ctrl1.ch_data}, {16'd0, exp1});
    $display("[TB] SCLK_HALF=1 frame ch_data=0x%04h", ctrl1.ch_data);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ads8688_manchn_ctrl.md
ADS8688_MANCHN_CTRL -- requirements
Module: ads8688_manchn_ctrl

Interface
REQ-001 Parameter SCLK_HALF, default 2: clk cycles per SCLK half-period; legal range is 1 or more.
REQ-002 Parameter CSN_IDLE, default 2: minimum clk cycles csn stays high between frames; legal range is 1 or more.
REQ-003 Port clk, in, 1: single system clock; all logic is on its rising edge.
REQ-004 Port arstn, in, 1: reset, asynchronous, active-low.
REQ-005 Port manchn_start, in, 1: one-clk request to run one manual-channel-select frame.
REQ-006 Port chsel, in, 16: command word (e.g. 0xC400 = MAN_Ch_1), sampled at frame start.
REQ-007 Port sclk, out, 1: SPI clock, CPOL=0 (idles low).
REQ-008 Port csn, out, 1: chip select, active-low.
REQ-009 Port mosi, out, 1: serial command to the ADC, MSB first.
REQ-010 Port miso, in, 1: serial conversion data from the ADC.
REQ-011 Port manchn_done, out, 1: one-clk pulse marking frame complete.
REQ-012 Port ch_data, out, 16: last captured conversion result.

Function
REQ-013 The block SHALL implement four states, IDLE, SETUP, SHIFT and DONE, all registered and glitch-free on the outputs.
REQ-014 In IDLE, a sampled manchn_start=1 SHALL do all of the following at that edge (E0): latch frame={chsel,16'h0000}, drive csn=0, drive mosi=frame[31], and enter SETUP.
REQ-015 manchn_start SHALL be ignored outside IDLE, and chsel changes after E0 SHALL NOT affect the current frame.
REQ-016 SCLK rising edge k (k=1..32) SHALL occur at E0+SCLK_HALF*(2k-1), and falling edge k SHALL occur at E0+SCLK_HALF*2k; exactly 32 SCLK pulses per frame.
REQ-017 After falling edge k (k=1..31), mosi SHALL equal frame[31-k]; bits 16..31 SHALL be the NO_OP 0x0000.
REQ-018 miso SHALL be sampled on rising edges k=17..32 into bit ch_data[32-k], MSB first.
REQ-019 At E0+65*SCLK_HALF (130 clk at default), the block SHALL, on the same edge: drive csn=1, drive sclk=0, drive mosi=0, load the 16 captured bits into ch_data, assert manchn_done for exactly one clk, and enter DONE.
REQ-020 The block SHALL stay in DONE until csn has been high for CSN_IDLE clk cycles, counting the done cycle, then return to IDLE; the earliest next start SHALL be accepted at that return.
REQ-021 ch_data SHALL hold its value between frame completions and SHALL NOT change mid-frame.
REQ-022 A start held high continuously SHALL produce back-to-back frames separated by CSN_IDLE high cycles.

Reset
REQ-023 While arstn=0, the block SHALL immediately force: state=IDLE, csn=1, sclk=0, mosi=0, manchn_done=0, ch_data=16'h0000, and all counters and shift registers to 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame without a done pulse, and ch_data SHALL read 0.
REQ-025 After arstn deasserts, a start SHALL be accepted on the first clk edge.

Configuration
REQ-026 With macro ADS8688_MISO_FALL_SAMPLE_EN defined, miso SHALL instead be sampled on SCLK falling edges k=17..32 into ch_data[32-k]; all other timing is unchanged.
REQ-027 Without ADS8688_MISO_FALL_SAMPLE_EN, miso SHALL be sampled on rising edges per REQ-018.

Verification
REQ-028 Basic frame, defaults: chsel=0xC400, pulse start, miso presents 0xA5A5 across bits 17..32 (changing on sclk falling edges) -> mosi sequence is 0xC400 then 0x0000, 32 sclk pulses, csn low for 130 clk, one manchn_done pulse, ch_data=0xA5A5.
REQ-029 Busy start: second start pulse at E0+40 with chsel=0xC800 -> ignored, mosi still carries 0xC400, only one done pulse.
REQ-030 Reset mid-frame: arstn low at E0+70 -> csn=1 and sclk=0 at once, ch_data=0, no done pulse; a new start after release runs a full frame.
REQ-031 Continuous start high, chsel=0xD000 then 0xC000 -> two frames with csn high exactly 2 clk between them; ch_data updates at each done.
REQ-032 SCLK_HALF=1, miso all 1s -> csn low 65 clk, ch_data=0xFFFF; with ADS8688_MISO_FALL_SAMPLE_EN, a falling-edge-aligned pattern 0x1234 -> ch_data=0x1234.
